// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, fetch reset defaults and the F/D entry type.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc4;
    } fd_entry_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read port between the fetch controller (master) and memory (slave).
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_ctrl_skid.sv
// One-entry skid buffer holding a fetched word and its PC+4 while decode is stalled.
module fetch_skid
    import cpu_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      load_i,
    input  logic      pop_i,
    input  fd_entry_t din_i,
    output fd_entry_t dout_o,
    output logic      valid_o
);
    fd_entry_t data_q, data_d;
    logic      valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = din_i;
            valid_d = 1'b1;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign dout_o  = data_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller with F/D register, stall skid and redirect handling.
// Define BRANCH_DELAY_SLOT_EN to deliver delay-slot words; otherwise they are squashed.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    fetch_ctrl_if.master imem,
    output logic [31:0] pc_f,
    output logic [31:0] ir_d,
    output logic [31:0] pc4_d,
    output logic        valid_d
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, tgt_q, tgt_d, ir_q, ir_n, pc4_q, pc4_n;
    logic         pend_q, pend_d, vld_q, vld_n;
    logic         ack_f, acc, slot, deliver, skid_load, skid_pop, skid_vld;
    fd_entry_t    skid_out;

    assign ack_f = (state_q == FETCH) && imem.imem_ack;
    assign acc   = redirect && vld_q && !stall;
    // Word acked alongside an accepted or outstanding redirect is the delay slot.
    assign slot  = acc || pend_q;
`ifdef BRANCH_DELAY_SLOT_EN
    assign deliver = ack_f;
`else
    assign deliver = ack_f && !slot;
`endif
    assign skid_load = deliver && stall;
    assign skid_pop  = (state_q == HOLD) && !stall && skid_vld;

    fetch_skid u_skid (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (skid_load),
        .pop_i   (skid_pop),
        .din_i   ('{word: imem.imem_rdata, pc4: pc_inc(pc_q)}),
        .dout_o  (skid_out),
        .valid_o (skid_vld)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (skid_load) state_d = HOLD;
            HOLD:    if (!stall) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem.imem_req = (state_q == FETCH);
    end

    always_comb begin
        pc_d   = pc_q;
        pend_d = pend_q;
        tgt_d  = tgt_q;
        ir_n   = ir_q;
        pc4_n  = pc4_q;
        vld_n  = vld_q;
        if (ack_f) begin
            pc_d   = acc ? redirect_pc : (pend_q ? tgt_q : pc_inc(pc_q));
            pend_d = 1'b0;
        end else if (acc) begin
            pend_d = 1'b1;
            tgt_d  = redirect_pc;
        end
        if (!stall) begin
            if (deliver) begin
                ir_n  = imem.imem_rdata;
                pc4_n = pc_inc(pc_q);
                vld_n = 1'b1;
            end else if (skid_pop) begin
                ir_n  = skid_out.word;
                pc4_n = skid_out.pc4;
                vld_n = 1'b1;
            end else begin
                ir_n  = NOP_WORD;
                vld_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            pend_q <= 1'b0;
            tgt_q  <= '0;
            ir_q   <= NOP_WORD;
            pc4_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            pend_q <= pend_d;
            tgt_q  <= tgt_d;
            ir_q   <= ir_n;
            pc4_q  <= pc4_n;
            vld_q  <= vld_n;
        end
    end

    assign imem.imem_addr = pc_q;
    assign pc_f           = pc_q;
    assign ir_d           = ir_q;
    assign pc4_d          = pc4_q;
    assign valid_d        = vld_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed scenarios then random traffic against a reference model.
module tb_fetch_ctrl;
    import cpu_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_3000;
    localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DS_EN = 1'b1;
`else
    localparam bit DS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_f, ir_d, pc4_d;
    logic        valid_d;

    fetch_ctrl_if bus ();

    fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus),
        .pc_f        (pc_f),
        .ir_d        (ir_d),
        .pc4_d       (pc4_d),
        .valid_d     (valid_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          req;
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] pc4;
        bit          v;
    } snap_t;

    snap_t       exp_q[$];
    fd_entry_t   m_skid[$];
    logic [31:0] m_pc, m_tgt, m_ir, m_pc4;
    bit          m_pend, m_v, m_run;
    int          checks = 0;
    int          passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural view: D either gets the fetched word, the parked word, or a bubble.
    task automatic model_step(input bit rst, input bit st, input bit rd, input logic [31:0] rpc,
                              input bit ack, input logic [31:0] wd);
        bit acc, slot, give;
        fd_entry_t e;
        if (rst) begin
            m_pc = RPC; m_pend = 0; m_tgt = 0; m_skid.delete();
            m_ir = NOP; m_pc4 = 0; m_v = 0; m_run = 0;
            return;
        end
        if (!m_run) begin
            m_run = 1;
            if (!st) begin m_ir = NOP; m_v = 0; end
            return;
        end
        acc = rd && m_v && !st;
        if (m_skid.size() != 0) begin
            if (acc) begin m_pend = 1; m_tgt = rpc; end
            if (!st) begin
                e = m_skid.pop_front();
                m_ir = e.word; m_pc4 = e.pc4; m_v = 1;
            end
        end else if (ack) begin
            slot = acc || m_pend;
            give = !slot || DS_EN;
            e.word = wd; e.pc4 = m_pc + 32'd4;
            m_pc = acc ? rpc : (m_pend ? m_tgt : m_pc + 32'd4);
            m_pend = 0;
            if (give && st) m_skid.push_back(e);
            else if (give) begin m_ir = e.word; m_pc4 = e.pc4; m_v = 1; end
            else if (!st) begin m_ir = NOP; m_v = 0; end
        end else begin
            if (acc) begin m_pend = 1; m_tgt = rpc; end
            if (!st) begin m_ir = NOP; m_v = 0; end
        end
    endtask

    task automatic cyc(input bit rst, input bit st, input bit rd, input logic [31:0] rpc,
                       input bit ack, input logic [31:0] wd);
        snap_t s;
        reset = rst; stall = st; redirect = rd; redirect_pc = rpc;
        bus.imem_ack = ack; bus.imem_rdata = wd;
        model_step(rst, st, rd, rpc, ack, wd);
        s.req = m_run && (m_skid.size() == 0);
        s.pc = m_pc; s.ir = m_ir; s.pc4 = m_pc4; s.v = m_v;
        exp_q.push_back(s);
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_req",   {31'd0, bus.imem_req}, {31'd0, e.req});
                chk("sb_addr",  bus.imem_addr, e.pc);
                chk("sb_pc_f",  pc_f, e.pc);
                chk("sb_ir_d",  ir_d, e.ir);
                chk("sb_pc4_d", pc4_d, e.pc4);
                chk("sb_valid", {31'd0, valid_d}, {31'd0, e.v});
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit          r, s, d, a;
        logic [31:0] tpc;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 32'hDEAD_0000);
        chk("rst_pc", pc_f, RPC);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, valid_d}, 32'd0);
        chk("rst_ir", ir_d, NOP);
        chk("rst_pc4", pc4_d, 32'd0);
        // IDLE ignores ack
        cyc(0, 0, 0, 0, 1, 32'hBAD0_0001);
        chk("idle_ir", ir_d, NOP);
        chk("fetch_addr0", bus.imem_addr, 32'h3000);
        cyc(0, 0, 0, 0, 1, 32'h2408_0001);
        chk("seq_addr1", bus.imem_addr, 32'h3004);
        chk("seq_valid", {31'd0, valid_d}, 32'd1);
        chk("seq_ir", ir_d, 32'h2408_0001);
        cyc(0, 0, 0, 0, 1, 32'h2408_0001);
        chk("seq_addr2", bus.imem_addr, 32'h3008);
        // stall 3 cycles, ack on the first
        cyc(0, 1, 0, 0, 1, 32'hAAAA_0001);
        chk("hold_req", {31'd0, bus.imem_req}, 32'd0);
        chk("hold_ir", ir_d, 32'h2408_0001);
        cyc(0, 1, 0, 0, 1, 32'hBAD0_0002);
        cyc(0, 1, 0, 0, 1, 32'hBAD0_0003);
        chk("hold_ir2", ir_d, 32'h2408_0001);
        chk("hold_addr", bus.imem_addr, 32'h300C);
        cyc(0, 0, 0, 0, 0, 0);
        chk("unhold_ir", ir_d, 32'hAAAA_0001);
        chk("unhold_pc4", pc4_d, 32'h300C);
        // redirect with same-cycle ack
        cyc(0, 0, 1, 32'h3040, 1, 32'hBBBB_0001);
        chk("br_addr", bus.imem_addr, 32'h3040);
        chk("br_slot_ir", ir_d, DS_EN ? 32'hBBBB_0001 : NOP);
        chk("br_slot_v", {31'd0, valid_d}, {31'd0, DS_EN});
        // redirect while ack withheld
        cyc(0, 0, 0, 0, 1, 32'hCCCC_0001);
        cyc(0, 0, 1, 32'h3040, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("pend_addr", bus.imem_addr, 32'h3044);
        cyc(0, 0, 0, 0, 1, 32'hDDDD_0001);
        chk("pend_target", bus.imem_addr, 32'h3040);
        chk("pend_slot_ir", ir_d, DS_EN ? 32'hDDDD_0001 : NOP);
        // wrap at top of address space
        cyc(0, 0, 0, 0, 1, 32'hEEEE_0001);
        cyc(0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_0001);
        chk("wrap_pre", pc_f, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 1, 32'h1234_5678);
        chk("wrap_pc", pc_f, 32'h0000_0000);
        chk("wrap_pc4", pc4_d, 32'h0000_0000);
        // reset mid-request with ack
        cyc(1, 0, 0, 0, 1, 32'h9999_0001);
        chk("mid_rst_pc", pc_f, RPC);
        chk("mid_rst_v", {31'd0, valid_d}, 32'd0);
        cyc(0, 0, 0, 0, 1, 32'h9999_0001);
        chk("post_rst_ir", ir_d, NOP);
        chk("post_rst_req", {31'd0, bus.imem_req}, 32'd1);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 4) == 0);
            a = ($urandom_range(0, 9) < 6);
            tpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
                                               : 32'h3000 + {22'd0, $urandom_range(0, 255), 2'b00};
            cyc(r, s, d, tpc, a, $urandom);
        end
        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_WORD, default 32'h0000_0000, meaning the instruction word driven on a bubble.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  in  1  D-stage hold request from the hazard unit.
REQ-006 SHALL have port redirect  in  1  D-stage jump or branch taken (jr, j, jal, beq taken).
REQ-007 SHALL have port redirect_pc  in  32  redirect target computed by the next-PC logic.
REQ-008 SHALL have port imem_req  out  1  instruction-memory read request.
REQ-009 SHALL have port imem_addr  out  32  fetch address, always equal to pc_f.
REQ-010 SHALL have port imem_ack  in  1  read data valid for the current request.
REQ-011 SHALL have port imem_rdata  in  32  fetched instruction word.
REQ-012 SHALL have port pc_f  out  32  current fetch PC.
REQ-013 SHALL have ports ir_d  out  32 and pc4_d  out  32  F/D pipeline register contents.
REQ-014 SHALL have port valid_d  out  1  ir_d holds a real instruction.

Function
REQ-015 SHALL implement the FSM states IDLE, FETCH and HOLD.
REQ-016 SHALL transition IDLE -> FETCH unconditionally on the first cycle after reset deassertion.
REQ-017 SHALL drive imem_req=1 only in FETCH, and SHALL ignore imem_ack in IDLE and HOLD.
REQ-018 SHALL define redirect as accepted only when redirect && valid_d && !stall.
REQ-019 SHALL, on acceptance without a same-cycle ack, register redirect_pc into a pending-target register and set pend=1.
REQ-020 SHALL, on FETCH with imem_ack, load pc_f <= redirect_pc if a redirect is accepted that cycle; else the pending target if pend; else pc_f+4. pend SHALL be cleared.
REQ-021 SHALL treat the word acked while a redirect is accepted or pending as the delay-slot instruction (see REQ-031).
REQ-022 SHALL, on FETCH with ack and !stall, load ir_d<=imem_rdata, pc4_d<=pc_f+4 and valid_d<=1, staying in FETCH.
REQ-023 SHALL, on FETCH with ack and stall, capture the word and PC+4 into the skid buffer and go to HOLD; F/D SHALL be unchanged.
REQ-024 SHALL, in HOLD with !stall, move the skid contents to F/D with valid_d=1 and go to FETCH; in HOLD with stall, remain in HOLD.
REQ-025 SHALL, when !stall and no word is delivered, load a bubble (ir_d<=NOP_WORD, valid_d<=0, pc4_d unchanged).
REQ-026 SHALL hold ir_d, pc4_d and valid_d unchanged whenever stall=1.
REQ-027 SHALL compute all PC arithmetic modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 0.

Reset
REQ-028 SHALL, when reset=1, set state=IDLE, pc_f=RESET_PC, pend=0, skid empty, ir_d=NOP_WORD, pc4_d=0, valid_d=0 and imem_req=0.
REQ-029 SHALL give reset priority over every other input and SHALL drop any outstanding request; an ack arriving during or after reset while in IDLE SHALL be ignored.

Configuration
REQ-030 SHALL use the macro BRANCH_DELAY_SLOT_EN to select delay-slot handling.
REQ-031 SHALL, with BRANCH_DELAY_SLOT_EN defined, deliver the delay-slot word to D normally (MIPS semantics); without it, SHALL discard the delay-slot word (F/D gets a bubble, skid is not loaded).

Structure
REQ-032 SHALL take the FSM state enum, RESET_PC default and NOP_WORD default from the shared package cpu_pkg.
REQ-033 SHALL place the one-entry skid buffer (word plus PC+4, valid flag) in the sub-module fetch_skid.

Verification
REQ-034 SHALL cover: reset, then ack every cycle with rdata=32'h2408_0001 -> imem_addr sequence 3000, 3004, 3008; valid_d rises on the cycle after the first ack.
REQ-035 SHALL cover: stall=1 for 3 cycles with ack on the first stalled cycle -> HOLD entered; ir_d frozen; the word appears in ir_d one cycle after stall drops; no address skipped.
REQ-036 SHALL cover: beq in D with redirect=1, redirect_pc=32'h0000_3040 and ack the same cycle -> next imem_addr=3040; delay-slot word valid in D with the macro, bubble without it.
REQ-037 SHALL cover: redirect accepted while ack is withheld for 2 cycles -> pend=1; the first acked word is the delay slot; the following address is 3040.
REQ-038 SHALL cover: reset asserted mid-request with ack on the same cycle -> pc_f=RESET_PC, valid_d=0, the acked word never reaches ir_d.
REQ-039 SHALL cover: pc_f forced to 32'hFFFF_FFFC with ack -> next pc_f=32'h0000_0000.
